mem_line_ctrl: RTL
==================

MEM_LINE_CTRL -- requirements
Module: mem_line_ctrl

Interface
REQ-001 TIMEOUT, 1023, max cycles waited for mem_ready in one transaction before abort.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  cache requests a line operation; sampled only in IDLE.
REQ-005 req_wb  input  1  victim line dirty; write back before fill.
REQ-006 req_addr  input  28  block address (byte address [31:4]) of line to fill.
REQ-007 wb_addr  input  28  block address of dirty victim.
REQ-008 wb_data  input  128  dirty victim line data.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 fill_valid  output  1  one-cycle pulse; fill_data valid.
REQ-011 fill_data  output  128  last line returned by memory.
REQ-012 err  output  1  sticky timeout flag.
REQ-013 mem_read  output  1  read strobe to slow memory.
REQ-014 mem_write  output  1  write strobe to slow memory.
REQ-015 mem_addr  output  28  block address to slow memory.
REQ-016 mem_wdata  output  128  write line to slow memory.
REQ-017 mem_rdata  input  128  read line from slow memory.
REQ-018 mem_ready  input  1  slow memory completion, sampled on rising edge.

Function
REQ-019 FSM states SHALL be IDLE, WB, GAP, FILL, DONE.
REQ-020 IDLE with req_valid=1: capture req_addr, wb_addr, wb_data into internal registers; go WB if req_wb=1, else FILL.
REQ-021 All request inputs SHALL be ignored while busy=1; memory outputs SHALL derive only from captured registers.
REQ-022 WB: mem_write=1, mem_addr=captured wb_addr, mem_wdata=captured wb_data, all held stable; edge with mem_ready=1 -> GAP.
REQ-023 GAP: exactly one cycle with mem_read=mem_write=0; -> FILL.
REQ-024 FILL: mem_read=1, mem_addr=captured req_addr; edge with mem_ready=1 -> latch mem_rdata into fill_data, go DONE.
REQ-025 DONE: fill_valid=1 for exactly one cycle; -> IDLE; new request acceptable on the following edge.
REQ-026 Strobes SHALL be registered/state-decoded, glitch-free, and never both high.
REQ-027 mem_ready SHALL be ignored in IDLE, GAP, DONE.
REQ-028 Latency: request accepted at edge t, mem_ready sampled at edge t+L -> fill_valid high in cycle after t+L (no writeback).
REQ-029 mem_wdata SHALL show captured wb_data at all times; mem_addr SHALL show captured req_addr outside WB.
REQ-030 Timeout counter, width ceil(log2(TIMEOUT+1)), cleared on entering WB or FILL, +1 per cycle without mem_ready; at TIMEOUT: set err, drop strobes, go IDLE, no fill_valid.
REQ-031 err SHALL stay 1 until reset; controller SHALL keep accepting requests while err=1.
REQ-032 fill_data SHALL hold its value until next successful fill.

Reset
REQ-033 rst_n=0 SHALL immediately, without clock, force IDLE and clear all outputs, fill_data, captured registers, counter and err to 0.
REQ-034 Reset mid-transaction SHALL abandon it; no fill_valid after release.

Verification
REQ-035 Clean fill: req_addr=28'h0000010, req_wb=0, memory latency 5 -> mem_read high until mem_ready edge, mem_write never high, fill_data=memory[0x10], one fill_valid pulse.
REQ-036 Dirty eviction: wb_addr=28'h0000020, wb_data=128'hDEADBEEF_..., req_addr=28'h0000030 -> write completes, one cycle both strobes 0, then read; memory[0x20]=wb_data; fill_data=memory[0x30].
REQ-037 Back-to-back: req_valid held high, two addresses -> second transaction starts only after DONE/IDLE; transactions never overlap.
REQ-038 Timeout: TIMEOUT=15, mem_ready tied 0 -> after 15 FILL cycles err=1, strobes 0, busy 0, no fill_valid; err remains 1.
REQ-039 Reset mid-FILL: rst_n=0 between edges -> mem_read and busy drop immediately; after release a new fill completes correctly.
REQ-040 Input churn: change req_addr and wb_data while busy -> mem_addr and mem_wdata unchanged until transaction ends.

Source files
------------

// File: rtl/mem_line_ctrl.sv
// Cache-line controller toward a slow memory: optional dirty-victim writeback,
// one idle gap cycle, then the line fill, with a per-transaction timeout.
module mem_line_ctrl #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    input  logic         req_wb,
    input  logic [27:0]  req_addr,
    input  logic [27:0]  wb_addr,
    input  logic [127:0] wb_data,
    output logic         busy,
    output logic         fill_valid,
    output logic [127:0] fill_data,
    output logic         err,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);
    localparam int unsigned AW = 28;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WB, GAP, FILL, DONE} state_t;

    state_t         state;
    state_t         next_state;
    logic           accept;
    logic           expire;
    logic [AW-1:0]  req_addr_q;
    logic [AW-1:0]  wb_addr_q;
    logic [AW-1:0]  cap_req_addr;
    logic [AW-1:0]  cap_wb_addr;
    logic [CW-1:0]  cnt;

    // The waiting cycle that would bring the counter to TIMEOUT aborts instead.
    assign expire = (cnt == CW'(TIMEOUT - 1)) && !mem_ready;

    // Captured addresses as they will be after this edge.
    assign cap_req_addr = accept ? req_addr : req_addr_q;
    assign cap_wb_addr  = accept ? wb_addr  : wb_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    next_state = req_wb ? WB : FILL;
                end
            end
            WB: begin
                if (mem_ready) begin
                    next_state = GAP;
                end else if (expire) begin
                    next_state = IDLE;
                end
            end
            GAP:  next_state = FILL;
            FILL: begin
                if (mem_ready) begin
                    next_state = DONE;
                end else if (expire) begin
                    next_state = IDLE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request capture; memory-side payload comes only from these registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_addr_q <= '0;
            wb_addr_q  <= '0;
            mem_wdata  <= '0;
        end else if (accept) begin
            req_addr_q <= req_addr;
            wb_addr_q  <= wb_addr;
            mem_wdata  <= wb_data;
        end
    end

    // Outputs registered from the next state so strobes are clean flop outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            mem_write  <= 1'b0;
            mem_read   <= 1'b0;
            fill_valid <= 1'b0;
            mem_addr   <= '0;
        end else begin
            busy       <= (next_state != IDLE);
            mem_write  <= (next_state == WB);
            mem_read   <= (next_state == FILL);
            fill_valid <= (next_state == DONE);
            mem_addr   <= (next_state == WB) ? cap_wb_addr : cap_req_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if ((next_state != state) && ((next_state == WB) || (next_state == FILL))) begin
            cnt <= '0;
        end else if (((state == WB) || (state == FILL)) && !mem_ready) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_data <= '0;
            err       <= 1'b0;
        end else begin
            if ((state == FILL) && mem_ready) begin
                fill_data <= mem_rdata;
            end
            if (((state == WB) || (state == FILL)) && expire) begin
                err <= 1'b1;
            end
        end
    end

endmodule
